fetch_unit: RTL

Instruction fetch stage for the in-order core. It holds the program counter and selects the next PC from sequential, branch, JAL and JALR sources supplied by the IF/ID register. It issues requests to instruction memory and discards responses from squashed requests. It buffers up to two returned instructions and presents them, with their PCs, to the IF/ID register.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 59 +++++
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: NOP encoding,
// next-PC select encodings, buffer depth and sequential PC step.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JAL    = 2'b10;
  localparam logic [1:0] PC_SEL_JALR   = 2'b11;

  localparam int FETCH_BUFFER_DEPTH = 2;
  localparam int PC_INCREMENT       = 4;

  typedef logic [1:0] pc_sel_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instruction, PC} between instruction memory and IF/ID.
// Flush empties it in one cycle; a push and a pop in the same cycle are both
// honoured. The caller guarantees no push when full and no pop when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic [ADDRESS_BITS-1:0] push_pc_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_data_o,
  output logic [ADDRESS_BITS-1:0] head_pc_o,
  output logic [1:0]              count_o,
  output logic                    empty_o
);

  logic [DATA_WIDTH-1:0]   data_q [FETCH_BUFFER_DEPTH];
  logic [ADDRESS_BITS-1:0] pc_q   [FETCH_BUFFER_DEPTH];
  logic                    rd_ptr_q;
  logic                    wr_ptr_q;
  logic [1:0]              count_q;

  // Entry storage; validity is carried by count_q, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) begin
      data_q[wr_ptr_q] <= push_data_i;
      pc_q[wr_ptr_q]   <= push_pc_i;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_data_o = data_q[rd_ptr_q];
  assign head_pc_o   = pc_q[rd_ptr_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, next-PC selection, instruction
// memory request/response handling with squash of stale responses, and a
// two-entry output buffer feeding IF/ID.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating perf_fetched
// and perf_squashed counter outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                        CORE            = 0,
  parameter int                        DATA_WIDTH      = 32,
  parameter int                        ADDRESS_BITS    = 20,
  parameter logic [ADDRESS_BITS-1:0]   PROGRAM_ADDRESS = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              next_PC_select,
  input  logic                    branch,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic [ADDRESS_BITS-1:0] JAL_target,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    stall,
  output logic                    imem_req_valid,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_rsp_data,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    inst_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_squashed
`endif
);

  // The core index only tags instances; it has no functional effect.
  if (CORE >= 0) begin : g_core_tag
  end

  logic                    redirect;
  logic [ADDRESS_BITS-1:0] target;
  logic                    pop;
  logic                    push;
  logic                    drop_rsp;
  logic                    accept;
  logic [2:0]              credits_used;

  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_BITS-1:0] rsp_pc_q, rsp_pc_d;
  logic [ADDRESS_BITS-1:0] last_pc_q;
  logic [1:0]              outstanding_q, outstanding_d;
  logic [1:0]              drop_count_q, drop_count_d;

  logic [DATA_WIDTH-1:0]   head_data;
  logic [ADDRESS_BITS-1:0] head_pc;
  logic [1:0]              buf_count;
  logic                    buf_empty;

  // Redirect decode and target selection.
  always_comb begin
    redirect = ((next_PC_select == PC_SEL_BRANCH) && branch) ||
               (next_PC_select == PC_SEL_JAL) ||
               (next_PC_select == PC_SEL_JALR);
    unique case (next_PC_select)
      PC_SEL_BRANCH: target = branch_target;
      PC_SEL_JAL:    target = JAL_target;
      PC_SEL_JALR:   target = JALR_target;
      default:       target = fetch_pc_q;
    endcase
  end

  // Credit check: the slot freed by a same-cycle pop is counted as available,
  // which keeps one request per cycle flowing with a 1-cycle memory while
  // still bounding outstanding + buffered at the buffer depth.
  always_comb begin
    pop          = !stall && !buf_empty && !redirect;
    credits_used = {1'b0, outstanding_q} + {1'b0, buf_count} - {2'b00, pop};
    imem_req_valid = reset && !redirect &&
                     (credits_used < 3'(FETCH_BUFFER_DEPTH));
    accept   = imem_req_valid && imem_req_ready;
    drop_rsp = imem_rsp_valid && (drop_count_q != 2'd0);
    push     = imem_rsp_valid && (drop_count_q == 2'd0) && !redirect;
  end

  // Next-state for PC, response-PC tracker, outstanding and drop counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, imem_rsp_valid};
    drop_count_d  = drop_count_q;
    if (redirect) begin
      // Everything still in flight belongs to the old path; the response
      // landing this cycle is discarded here and must not be counted again.
      fetch_pc_d   = target;
      rsp_pc_d     = target;
      drop_count_d = outstanding_q - {1'b0, imem_rsp_valid};
    end else begin
      if (accept)   fetch_pc_d   = fetch_pc_q + ADDRESS_BITS'(PC_INCREMENT);
      if (push)     rsp_pc_d     = rsp_pc_q + ADDRESS_BITS'(PC_INCREMENT);
      if (drop_rsp) drop_count_d = drop_count_q - 2'd1;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= PROGRAM_ADDRESS;
      rsp_pc_q      <= PROGRAM_ADDRESS;
      last_pc_q     <= PROGRAM_ADDRESS;
      outstanding_q <= 2'd0;
      drop_count_q  <= 2'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      if (!buf_empty) last_pc_q <= head_pc;
    end
  end

  fetch_buffer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_fetch_buffer (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (imem_rsp_data),
    .push_pc_i   (rsp_pc_q),
    .pop_i       (pop),
    .head_data_o (head_data),
    .head_pc_o   (head_pc),
    .count_o     (buf_count),
    .empty_o     (buf_empty)
  );

  assign imem_req_addr = fetch_pc_q;
  assign inst_valid    = !buf_empty;
  assign instruction   = buf_empty ? DATA_WIDTH'(NOP_INSTRUCTION) : head_data;
  assign inst_PC       = buf_empty ? last_pc_q : head_pc;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_squashed_q;
  logic [1:0]  squash_inc;
  logic [32:0] fetched_sum;
  logic [32:0] squashed_sum;

  // Squashed = responses dropped by the drop counter plus whatever a redirect
  // discards (buffered entries and the response landing that cycle).
  always_comb begin
    squash_inc   = redirect ? (buf_count + {1'b0, imem_rsp_valid})
                            : {1'b0, drop_rsp};
    fetched_sum  = {1'b0, perf_fetched_q} + {32'd0, push};
    squashed_sum = {1'b0, perf_squashed_q} + {31'd0, squash_inc};
  end

  // Saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_q  <= 32'd0;
      perf_squashed_q <= 32'd0;
    end else begin
      perf_fetched_q  <= fetched_sum[32]  ? 32'hFFFF_FFFF : fetched_sum[31:0];
      perf_squashed_q <= squashed_sum[32] ? 32'hFFFF_FFFF : squashed_sum[31:0];
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`else
  // Counters are not built; behaviour is otherwise identical.
`endif

endmodule
